// File: rtl/ddc112_if.sv
// Host <-> DDC112 serial readout signals.
// master = host readout logic, slave = device emulator.
interface ddc112_if #(
    parameter int unsigned DATA_W = 20
) ();
    logic              CONV;
    logic              DXMIT_BAR;
    logic              DCLK;
    logic [DATA_W-1:0] CH1;
    logic [DATA_W-1:0] CH2;
    logic              DVALID_BAR;
    logic              DOUT;
    logic              side;
    logic              overrun;
    logic              short_read;
    logic              busy;

    modport master (
        output CONV, DXMIT_BAR, DCLK, CH1, CH2,
        input  DVALID_BAR, DOUT, side, overrun, short_read, busy
    );

    modport slave (
        input  CONV, DXMIT_BAR, DCLK, CH1, CH2,
        output DVALID_BAR, DOUT, side, overrun, short_read, busy
    );
endinterface

// File: rtl/ddc112_emulator.sv
// Device-side DDC112 serial responder: converts CH1/CH2 on each CONV toggle and
// shifts the 2-word result out on DOUT under host DXMIT_BAR/DCLK control.
module ddc112_emulator #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned T_CONV = 16
) (
    input logic     clk,
    input logic     RST_BAR,
    ddc112_if.slave bus
);
    localparam int unsigned WordW  = 2 * DATA_W;
    localparam int unsigned TimerW = $clog2(T_CONV);
    localparam int unsigned CntW   = $clog2(WordW) + 1;

    typedef enum logic [1:0] {StIdle, StValid, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic               conv_q, dxmit_q, dclk_q;
    logic               conv_edge, dxmit_fall, dxmit_rise, dclk_rise;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               busy_q, busy_d;
    logic               side_q, side_d;
    logic [WordW-1:0]   hold_q, hold_d;
    logic               ready, conv_ovr;
    logic [WordW-1:0]   sr_q, sr_d;
    logic [CntW-1:0]    bitcnt_q, bitcnt_d;
    logic               pend_q, pend_d;
    logic [WordW-1:0]   pend_word_q, pend_word_d;
    logic               overrun_q, overrun_d;
    logic               short_q, short_d;

    // Pins are compared against their one-clock-old copy.
    assign conv_edge  = bus.CONV != conv_q;
    assign dxmit_fall = dxmit_q & ~bus.DXMIT_BAR;
    assign dxmit_rise = ~dxmit_q & bus.DXMIT_BAR;
    assign dclk_rise  = ~dclk_q & bus.DCLK;
    assign ready      = busy_q && (timer_q == '0);

    always_comb begin
        timer_d  = timer_q;
        busy_d   = busy_q;
        hold_d   = hold_q;
        side_d   = side_q;
        conv_ovr = 1'b0;
        if (conv_edge) begin
            hold_d   = {bus.CH2, bus.CH1};
            side_d   = bus.CONV;
            timer_d  = TimerW'(T_CONV - 1);
            busy_d   = 1'b1;
            // An edge landing on expiry still delivers the old word, so nothing is lost.
            conv_ovr = busy_q && !ready;
        end else if (busy_q) begin
            if (ready) begin
                busy_d = 1'b0;
            end else begin
                timer_d = timer_q - TimerW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        overrun_d   = conv_ovr;
        short_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ready) begin
                    sr_d    = hold_q;
                    state_d = StValid;
                    if (pend_q) begin
                        overrun_d = 1'b1;
                    end
                    pend_d  = 1'b0;
                end else if (pend_q) begin
                    sr_d    = pend_word_q;
                    pend_d  = 1'b0;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (ready) begin
                    sr_d      = hold_q;
                    overrun_d = 1'b1;
                end
                if (dxmit_fall) begin
                    state_d  = StShift;
                    bitcnt_d = '0;
                end
            end
            StShift: begin
                if (dxmit_rise) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                end else if (dclk_rise) begin
                    sr_d = sr_q << 1;
                    if (bitcnt_q != CntW'(WordW)) begin
                        bitcnt_d = bitcnt_q + CntW'(1);
                    end
                    if (bitcnt_q == CntW'(WordW - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (dxmit_rise) begin
                    state_d = StIdle;
                end
            end
        endcase
        // The shift register is busy here, so a new word waits until IDLE.
        if ((state_q == StShift || state_q == StDone) && ready) begin
            pend_word_d = hold_q;
            pend_d      = 1'b1;
            if (pend_q) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RST_BAR) begin
        if (!RST_BAR) begin
            state_q     <= StIdle;
            conv_q      <= 1'b0;
            dxmit_q     <= 1'b1;
            dclk_q      <= 1'b0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            side_q      <= 1'b0;
            hold_q      <= '0;
            sr_q        <= '0;
            bitcnt_q    <= '0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            overrun_q   <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_q      <= bus.CONV;
            dxmit_q     <= bus.DXMIT_BAR;
            dclk_q      <= bus.DCLK;
            timer_q     <= timer_d;
            busy_q      <= busy_d;
            side_q      <= side_d;
            hold_q      <= hold_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            overrun_q   <= overrun_d;
            short_q     <= short_d;
        end
    end

    assign bus.DVALID_BAR = (state_q != StValid);
    assign bus.DOUT       = (state_q == StValid || state_q == StShift) ? sr_q[WordW-1] : 1'b0;
    assign bus.side       = side_q;
    assign bus.overrun    = overrun_q;
    assign bus.short_read = short_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ddc112_emulator.sv
// Bench for ddc112_emulator: acts as the host readout, scoreboards delivered words.
module tb_ddc112_emulator;
    logic clk = 1'b0;
    logic RST_BAR = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   ovr_cnt = 0;
    int   short_cnt = 0;
    logic exp_side = 1'b0;
    logic [39:0] exp_q[$];

    always #5 clk = ~clk;

    ddc112_if #(.DATA_W(20)) bus ();

    ddc112_emulator #(.DATA_W(20), .T_CONV(16)) dut (
        .clk     (clk),
        .RST_BAR (RST_BAR),
        .bus     (bus)
    );

    always @(negedge clk) begin
        if (bus.overrun === 1'b1) ovr_cnt++;
        if (bus.short_read === 1'b1) short_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Toggle CONV with new channel data; replace models a word that will be overwritten.
    task automatic start_conv(input logic [19:0] c2, input logic [19:0] c1, input bit replace);
        tick();
        bus.CH2  = c2;
        bus.CH1  = c1;
        bus.CONV = ~bus.CONV;
        exp_side = bus.CONV;
        if (replace && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back({c2, c1});
    endtask

    // k-th iteration samples just after the k-th posedge following the toggle.
    task automatic measure(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy === 1'b1) busy_n++;
            if (bus.DVALID_BAR === 1'b0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int budget);
        bit timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.DVALID_BAR === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check("dvalid_wait_timeout", 64'(timed_out), 64'd0);
    endtask

    task automatic read_bits(input int nbits, output logic [39:0] got);
        got = '0;
        tick();
        bus.DXMIT_BAR = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("dvalid_high_in_shift", 64'(bus.DVALID_BAR), 64'd1);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            got = {got[38:0], bus.DOUT};
            tick();
            bus.DCLK = 1'b1;
            tick();
            tick();
            bus.DCLK = 1'b0;
            tick();
        end
    endtask

    task automatic read_word(input string tag);
        logic [39:0] got;
        logic [39:0] exp_w;
        wait_valid(100);
        read_bits(40, got);
        @(negedge clk);
        check({tag, "_dout_done"}, 64'(bus.DOUT), 64'd0);
        tick();
        bus.DXMIT_BAR = 1'b1;
        tick();
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            exp_w = exp_q.pop_front();
            check(tag, 64'(got), 64'(exp_w));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, busy_n, o0, s0;
        logic [39:0] got;
        logic [39:0] exp_w;

        bus.CONV = 1'b0;
        bus.DXMIT_BAR = 1'b1;
        bus.DCLK = 1'b0;
        bus.CH1 = '0;
        bus.CH2 = '0;
        #23;
        check("reset_outputs",
              64'({bus.DVALID_BAR, bus.DOUT, bus.side, bus.overrun, bus.short_read, bus.busy}),
              64'b100000);
        RST_BAR = 1'b1;
        repeat (3) tick();

        // Basic conversion timing and a full readout.
        start_conv(20'hA5A5A, 20'h12345, 1'b0);
        measure(lat, busy_n);
        check("t1_latency", 64'(lat), 64'd17);
        check("t1_busy_cycles", 64'(busy_n), 64'd16);
        check("t1_side", 64'(bus.side), 64'(exp_side));
        read_word("t2_word");
        check("t2_no_pulses", 64'({ovr_cnt, short_cnt}), 64'd0);

        // Restart while busy: one overrun, second capture delivered.
        o0 = ovr_cnt;
        start_conv(20'h11111, 20'h22222, 1'b0);
        repeat (5) tick();
        start_conv(20'h3C3C3, 20'hC3C3C, 1'b1);
        measure(lat, busy_n);
        check("t3_latency", 64'(lat), 64'd17);
        check("t3_overrun", 64'(ovr_cnt - o0), 64'd1);
        check("t3_side", 64'(bus.side), 64'(exp_side));
        read_word("t3_word");

        // Unread word overwritten at expiry.
        start_conv(20'h0F0F0, 20'hF0F0F, 1'b0);
        wait_valid(40);
        o0 = ovr_cnt;
        start_conv(20'h00000, 20'h00001, 1'b1);
        repeat (5) tick();
        check("t4_no_early_overrun", 64'(ovr_cnt - o0), 64'd0);
        repeat (20) tick();
        check("t4_overrun", 64'(ovr_cnt - o0), 64'd1);
        check("t4_still_valid", 64'(bus.DVALID_BAR), 64'd0);
        read_word("t4_word");

        // Short read with a word pended during the shift.
        start_conv(20'h9ABCD, 20'h55AA5, 1'b0);
        wait_valid(40);
        o0 = ovr_cnt;
        s0 = short_cnt;
        start_conv(20'h7E7E7, 20'h81818, 1'b0);
        read_bits(10, got);
        exp_w = exp_q.pop_front();
        check("t5_partial_bits", 64'(got[9:0]), 64'(exp_w[39:30]));
        bus.DXMIT_BAR = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_short_pulse", 64'(bus.short_read), 64'd1);
        check("t5_idle_dvalid", 64'(bus.DVALID_BAR), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("t5_pend_dvalid", 64'(bus.DVALID_BAR), 64'd0);
        check("t5_short_count", 64'(short_cnt - s0), 64'd1);
        check("t5_no_overrun", 64'(ovr_cnt - o0), 64'd0);
        read_word("t5_pend_word");

        // Asynchronous reset in the middle of a shift.
        start_conv(20'hFFFFF, 20'hFFFFF, 1'b0);
        wait_valid(40);
        read_bits(7, got);
        check("t6_dout_before_reset", 64'(bus.DOUT), 64'd1);
        #2;
        RST_BAR = 1'b0;
        #1;
        check("t6_async_outputs", 64'({bus.DOUT, bus.DVALID_BAR}), 64'b01);
        void'(exp_q.pop_front());
        bus.DXMIT_BAR = 1'b1;
        bus.DCLK = 1'b0;
        bus.CONV = 1'b0;
        exp_side = 1'b0;
        repeat (3) tick();
        o0 = ovr_cnt;
        s0 = short_cnt;
        RST_BAR = 1'b1;
        repeat (30) tick();
        check("t6_no_pulses_after", 64'({ovr_cnt - o0, short_cnt - s0}), 64'd0);
        check("t6_idle_after", 64'({bus.DVALID_BAR, bus.busy, bus.side}), 64'b100);

        // Normal operation resumes after reset.
        start_conv(20'h13579, 20'h2468A, 1'b0);
        read_word("t6_recover_word");
        check("t6_recover_side", 64'(bus.side), 64'(exp_side));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
